// File: rtl/hci_core_load_resp_buffer_pkg.sv
// Shared HCI types and defaults for the load response buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hci_package;

  localparam int unsigned DEFAULT_DW = 32;
  localparam int unsigned DEFAULT_AW = 32;
  localparam int unsigned DEFAULT_UW = 1;
  // Byte-offset field carried alongside each TCDM request.
  localparam int unsigned BOFFS_W    = 16;

  // cnt is wide enough for the largest legal DEPTH (64).
  typedef struct packed {
    logic [6:0] cnt;
    logic       full;
    logic       empty;
  } hci_core_load_resp_buffer_flags_t;

endpackage

// File: rtl/hci_core_load_resp_buffer_fifo.sv
// Generic circular FIFO holding returned load words.
// Latency: a word pushed in cycle t is presented on pop_data with pop_valid in t+1.
// Backpressure: pop side is valid/ready; push_ready drops when all FIFO_DEPTH slots are used.
// Ports: clk_i/rst_ni/clear_i; push_valid/push_ready/push_data in; pop_valid/pop_ready/pop_data out;
//        occupancy = number of stored words.
module hwpe_stream_fifo #(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [CW-1:0]         occupancy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         occ_q;
  logic                  do_push, do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push_ready = (occ_q != CW'(FIFO_DEPTH));
  assign pop_valid  = (occ_q != '0);
  assign pop_data   = mem_q[rd_ptr_q];
  assign occupancy  = occ_q;
  assign do_push    = push_valid & push_ready;
  assign do_pop     = pop_valid & pop_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      occ_q <= occ_q + CW'(1);
      else if (!do_push && do_pop) occ_q <= occ_q - CW'(1);
    end
  end

  // Storage needs no reset: a slot is only observable once occupancy covers it.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/hci_core_load_resp_buffer.sv
// Credit-gated load path: forwards load requests and buffers returned data as a stream.
// Latency: requests pass combinationally; a returned word appears on resp one cycle after r_valid.
// Backpressure: resp is valid/ready; requests are held off (req/gnt masked) while DEPTH loads are unpopped.
// Ports: clk_i, rst_ni (async, active-low), clear_i (sync); tcdm_slave_* from the source engine;
//        tcdm_master_* to the load channel; resp_* buffered data stream; flags_o occupancy/full/empty.
module hci_core_load_resp_buffer
  import hci_package::*;
#(
  parameter int unsigned DW    = DEFAULT_DW,
  parameter int unsigned AW    = DEFAULT_AW,
  parameter int unsigned UW    = DEFAULT_UW,
  // Max outstanding plus buffered loads, 2..64.
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  // source engine side
  input  logic                             tcdm_slave_req,
  output logic                             tcdm_slave_gnt,
  input  logic [AW-1:0]                    tcdm_slave_add,
  input  logic                             tcdm_slave_wen,
  input  logic [DW-1:0]                    tcdm_slave_data,
  input  logic [DW/8-1:0]                  tcdm_slave_be,
  input  logic [BOFFS_W-1:0]               tcdm_slave_boffs,
  input  logic [UW-1:0]                    tcdm_slave_user,
  output logic [DW-1:0]                    tcdm_slave_r_data,
  output logic                             tcdm_slave_r_valid,
  output logic                             tcdm_slave_r_opc,
  output logic [UW-1:0]                    tcdm_slave_r_user,
  input  logic                             tcdm_slave_lrdy,
  // load channel side
  output logic                             tcdm_master_req,
  input  logic                             tcdm_master_gnt,
  output logic [AW-1:0]                    tcdm_master_add,
  output logic                             tcdm_master_wen,
  output logic [DW-1:0]                    tcdm_master_data,
  output logic [DW/8-1:0]                  tcdm_master_be,
  output logic [BOFFS_W-1:0]               tcdm_master_boffs,
  output logic [UW-1:0]                    tcdm_master_user,
  input  logic [DW-1:0]                    tcdm_master_r_data,
  input  logic                             tcdm_master_r_valid,
  input  logic                             tcdm_master_r_opc,
  input  logic [UW-1:0]                    tcdm_master_r_user,
  output logic                             tcdm_master_lrdy,
  // buffered data stream
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [DW-1:0]                    resp_data,
  output logic [DW/8-1:0]                  resp_strb,
  output hci_core_load_resp_buffer_flags_t flags_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0] cnt_q, cnt_d, fifo_cnt;
  logic          full, empty, grant, pop, fifo_push_ready;

  // Credits: every granted load owns a FIFO slot until its data is popped,
  // so the FIFO can never overflow regardless of resp_ready.
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign grant = tcdm_master_req & tcdm_master_gnt;
  assign pop   = resp_valid & resp_ready;

  assign tcdm_master_req   = tcdm_slave_req & ~full;
  assign tcdm_slave_gnt    = tcdm_master_gnt & ~full;
  assign tcdm_master_add   = tcdm_slave_add;
  assign tcdm_master_be    = tcdm_slave_be;
  assign tcdm_master_boffs = tcdm_slave_boffs;
  assign tcdm_master_user  = tcdm_slave_user;
  assign tcdm_master_wen   = 1'b1;
  assign tcdm_master_data  = '0;
  assign tcdm_master_lrdy  = 1'b1;

  // Data goes out on resp, never back on the slave response channel.
  assign tcdm_slave_r_valid = 1'b0;
  assign tcdm_slave_r_data  = '0;
  assign tcdm_slave_r_opc   = 1'b0;
  assign tcdm_slave_r_user  = '0;

  assign resp_strb = '1;

  always_comb begin
    cnt_d = cnt_q;
    if (grant && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!grant && pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      cnt_q <= '0;
    else if (clear_i) cnt_q <= '0;
    else              cnt_q <= cnt_d;
  end

  hwpe_stream_fifo #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) i_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .push_valid (tcdm_master_r_valid),
    .push_ready (fifo_push_ready),
    .push_data  (tcdm_master_r_data),
    .pop_valid  (resp_valid),
    .pop_ready  (resp_ready),
    .pop_data   (resp_data),
    .occupancy  (fifo_cnt)
  );

  always_comb begin
    flags_o       = '0;
    flags_o.cnt   = 7'(cnt_q);
    flags_o.full  = full;
    flags_o.empty = empty;
  end

  // Write-side and opcode fields of the interfaces carry nothing for a load-only path.
  logic unused_inputs;
  assign unused_inputs = ^{tcdm_slave_wen, tcdm_slave_data, tcdm_slave_lrdy,
                           tcdm_master_r_opc, tcdm_master_r_user, fifo_push_ready};

  // A response with no free slot means the credit gating was bypassed.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    tcdm_master_r_valid |-> fifo_push_ready);

  // Clearing with loads still in flight would let their data land after the clear.
  a_clear_idle : assert property (@(posedge clk_i) disable iff (!rst_ni)
    clear_i |-> (cnt_q == fifo_cnt));

endmodule
